rf_access_seq: RTL

//  Debug/boot initiator that drives the register-file write port and one read port.

---
 rtl/rf_seq_pkg.sv | 27 ++
 rtl/rf_seq_rsp_buf.sv | 43 ++++
 rtl/rf_access_seq.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/rf_seq_pkg.sv
// Shared types and defaults for the register-file access sequencer.
// Optional write readback check: RF_SEQ_READBACK_CHECK_EN.
package rf_seq_pkg;

    localparam int RF_NREGS = 32;
    localparam int RF_AW    = $clog2(RF_NREGS);
    localparam int RF_DW    = 32;

    typedef enum logic [1:0] {
        OP_WRITE = 2'b00,
        OP_READ  = 2'b01,
        OP_DUMP  = 2'b10,
        OP_CLEAR = 2'b11
    } op_e;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE = 3'd0;
    localparam state_t ST_WR   = 3'd1;
    localparam state_t ST_RD   = 3'd2;
    localparam state_t ST_RSP  = 3'd3;
    localparam state_t ST_CLR  = 3'd4;
    localparam state_t ST_DRD  = 3'd5;
    localparam state_t ST_DRSP = 3'd6;
    localparam state_t ST_WCHK = 3'd7;

endpackage

// File: rtl/rf_seq_rsp_buf.sv
// Response holding register: loads a read word, holds it until consumed.
module rf_seq_rsp_buf #(
    parameter int AW = 5,
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load_i,
    input  logic          clr_i,
    input  logic [AW-1:0] addr_i,
    input  logic [DW-1:0] data_i,
    input  logic          last_i,
    output logic          valid_o,
    output logic [AW-1:0] addr_o,
    output logic [DW-1:0] data_o,
    output logic          last_o
);

    logic          valid_q;
    logic [AW-1:0] addr_q;
    logic [DW-1:0] data_q;
    logic          last_q;

    always_ff @(posedge clk) begin
        if (rst || clr_i) begin
            valid_q <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
            last_q  <= 1'b0;
        end else if (load_i) begin
            valid_q <= 1'b1;
            addr_q  <= addr_i;
            data_q  <= data_i;
            last_q  <= last_i;
        end
    end

    assign valid_o = valid_q;
    assign addr_o  = addr_q;
    assign data_o  = data_q;
    assign last_o  = last_q;

endmodule

// File: rtl/rf_access_seq.sv
// Debug/boot register-file sequencer: WRITE/READ/DUMP/CLEAR over valid/ready.
// Define RF_SEQ_READBACK_CHECK_EN to add a readback check after each WRITE.
module rf_access_seq
    import rf_seq_pkg::*;
#(
    parameter int NREGS = RF_NREGS,
    parameter int AW    = RF_AW,
    parameter int DW    = RF_DW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic [1:0]    cmd_op,
    input  logic [AW-1:0] cmd_addr,
    input  logic [DW-1:0] cmd_wdata,
    output logic          rsp_valid,
    input  logic          rsp_ready,
    output logic [AW-1:0] rsp_addr,
    output logic [DW-1:0] rsp_data,
    output logic          rsp_last,
    output logic          rf_wr,
    output logic [AW-1:0] rf_wr_addr,
    output logic [DW-1:0] rf_wr_data,
    output logic [AW-1:0] rf_rd_addr,
    input  logic [DW-1:0] rf_rd_data,
    output logic          busy,
    output logic          chk_err
);

    localparam logic [AW:0] LAST_IDX = (AW+1)'(NREGS - 1);

    state_t        state_q, state_d;
    logic [AW:0]   idx_q, idx_d, idx_nxt;
    logic [AW-1:0] addr_q, addr_d;
    logic [AW-1:0] rd_addr_q, rd_addr_d;
    logic [DW-1:0] wdata_q, wdata_d;
    logic [DW-1:0] rd_data_z;
    logic          buf_load, buf_last, rsp_hs;
`ifdef RF_SEQ_READBACK_CHECK_EN
    logic          chk_err_q, chk_err_d;
`endif

    // x0 is architecturally zero regardless of what the array returns
    assign rd_data_z = (rd_addr_q == '0) ? '0 : rf_rd_data;
    assign rsp_hs    = rsp_valid & rsp_ready;
    assign idx_nxt   = idx_q + 1'b1;

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        addr_d    = addr_q;
        rd_addr_d = rd_addr_q;
        wdata_d   = wdata_q;
        buf_load  = 1'b0;
        buf_last  = 1'b0;
`ifdef RF_SEQ_READBACK_CHECK_EN
        chk_err_d = chk_err_q;
`endif
        unique case (state_q)
            ST_IDLE: begin
                if (cmd_valid) begin
                    addr_d    = cmd_addr;
                    wdata_d   = cmd_wdata;
                    rd_addr_d = cmd_addr;
                    unique case (op_e'(cmd_op))
                        OP_WRITE: state_d = ST_WR;
                        OP_READ:  state_d = ST_RD;
                        OP_DUMP: begin
                            state_d   = ST_DRD;
                            idx_d     = '0;
                            rd_addr_d = '0;
                        end
                        OP_CLEAR: begin
                            state_d = ST_CLR;
                            idx_d   = (AW+1)'(1);
                        end
                    endcase
                end
            end
            ST_WR: begin
`ifdef RF_SEQ_READBACK_CHECK_EN
                state_d = (addr_q != '0) ? ST_WCHK : ST_IDLE;
`else
                state_d = ST_IDLE;
`endif
            end
`ifdef RF_SEQ_READBACK_CHECK_EN
            ST_WCHK: begin
                state_d = ST_IDLE;
                if (rf_rd_data != wdata_q) chk_err_d = 1'b1;
            end
`endif
            ST_RD: begin
                buf_load = 1'b1;
                buf_last = 1'b1;
                state_d  = ST_RSP;
            end
            ST_RSP: begin
                if (rsp_hs) state_d = ST_IDLE;
            end
            ST_DRD: begin
                buf_load = 1'b1;
                buf_last = (idx_q == LAST_IDX);
                state_d  = ST_DRSP;
            end
            ST_DRSP: begin
                if (rsp_hs) begin
                    if (idx_q == LAST_IDX) begin
                        state_d = ST_IDLE;
                    end else begin
                        idx_d     = idx_nxt;
                        rd_addr_d = idx_nxt[AW-1:0];
                        state_d   = ST_DRD;
                    end
                end
            end
            ST_CLR: begin
                if (idx_q == LAST_IDX) state_d = ST_IDLE;
                else idx_d = idx_nxt;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            idx_q     <= '0;
            addr_q    <= '0;
            rd_addr_q <= '0;
            wdata_q   <= '0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            addr_q    <= addr_d;
            rd_addr_q <= rd_addr_d;
            wdata_q   <= wdata_d;
        end
    end

`ifdef RF_SEQ_READBACK_CHECK_EN
    always_ff @(posedge clk) begin
        if (rst) chk_err_q <= 1'b0;
        else chk_err_q <= chk_err_d;
    end
    assign chk_err = chk_err_q;
`else
    assign chk_err = 1'b0;
`endif

    rf_seq_rsp_buf #(
        .AW(AW),
        .DW(DW)
    ) u_rsp_buf (
        .clk    (clk),
        .rst    (rst),
        .load_i (buf_load),
        .clr_i  (rsp_hs),
        .addr_i (rd_addr_q),
        .data_i (rd_data_z),
        .last_i (buf_last),
        .valid_o(rsp_valid),
        .addr_o (rsp_addr),
        .data_o (rsp_data),
        .last_o (rsp_last)
    );

    assign cmd_ready  = (state_q == ST_IDLE);
    assign busy       = (state_q != ST_IDLE);
    assign rf_rd_addr = rd_addr_q;
    assign rf_wr      = (state_q == ST_CLR) ||
                        ((state_q == ST_WR) && (addr_q != '0));
    assign rf_wr_addr = (state_q == ST_CLR) ? idx_q[AW-1:0] :
                        (state_q == ST_WR)  ? addr_q : '0;
    assign rf_wr_data = (state_q == ST_WR) ? wdata_q : '0;

endmodule
